// File: rtl/cache_bus_arbiter.sv
// cache_bus_arbiter: shares one SRAM-like bus between the icache (m0) and
// dcache (m1) refill engines. The grant is locked for a whole burst and
// released when the owner drops its en. A per-beat watchdog pulses bus_err
// when the owned bus goes TIMEOUT stalled cycles without sram_rvalid.
// Optional feature macro: ARB_ROUND_ROBIN_EN (alternate owners when both
// request in IDLE). Without it, m1 has fixed priority over m0.
module cache_bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                m0_en,
    input  logic [DATA_W/8-1:0] m0_wen,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W-1:0]   m0_wdata,
    output logic                m0_rvalid,
    input  logic                m1_en,
    input  logic [DATA_W/8-1:0] m1_wen,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    output logic                m1_rvalid,
    output logic [DATA_W-1:0]   m_rdata,
    output logic                sram_en,
    output logic [DATA_W/8-1:0] sram_wen,
    output logic [ADDR_W-1:0]   sram_addr,
    output logic [DATA_W-1:0]   sram_wdata,
    input  logic [DATA_W-1:0]   sram_rdata,
    input  logic                sram_rvalid,
    output logic [1:0]          grant,
    output logic                bus_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    // Watchdog terminal count; the pulse fires on the TIMEOUT-th stalled cycle.
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  grant_q;
    logic [15:0] wdog;
    logic        own_en;

`ifdef ARB_ROUND_ROBIN_EN
    // Most recent owner: 0 = m0, 1 = m1.
    logic        last;
`endif

    // State register; grant is registered alongside it so it is glitch-free.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            grant_q <= 2'b00;
        end else begin
            state   <= state_nxt;
            grant_q <= {state_nxt == OWN1, state_nxt == OWN0};
        end
    end

    // Next-state: arbitrate only from IDLE, hold the owner until it drops en.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
`ifdef ARB_ROUND_ROBIN_EN
                if (m0_en && m1_en) state_nxt = last ? OWN0 : OWN1;
                else if (m1_en)     state_nxt = OWN1;
                else if (m0_en)     state_nxt = OWN0;
`else
                if (m1_en)      state_nxt = OWN1;
                else if (m0_en) state_nxt = OWN0;
`endif
            end
            OWN0:    if (!m0_en) state_nxt = IDLE;
            OWN1:    if (!m1_en) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output mux: route the owner onto the bus; idle bus is driven to zero.
    always_comb begin
        sram_en    = 1'b0;
        sram_wen   = '0;
        sram_addr  = '0;
        sram_wdata = '0;
        m0_rvalid  = 1'b0;
        m1_rvalid  = 1'b0;
        own_en     = 1'b0;
        case (state)
            OWN0: begin
                sram_en    = m0_en;
                sram_wen   = m0_wen;
                sram_addr  = m0_addr;
                sram_wdata = m0_wdata;
                m0_rvalid  = sram_rvalid;
                own_en     = m0_en;
            end
            OWN1: begin
                sram_en    = m1_en;
                sram_wen   = m1_wen;
                sram_addr  = m1_addr;
                sram_wdata = m1_wdata;
                m1_rvalid  = sram_rvalid;
                own_en     = m1_en;
            end
            default: ;
        endcase
    end

    assign grant   = grant_q;
    assign m_rdata = sram_rdata;

    // Pulse in the cycle the counter sits at its terminal value with no rvalid.
    assign bus_err = (state != IDLE) && own_en && !sram_rvalid && (wdog == WD_LAST);

    // Watchdog: counts stalled owned cycles, restarts on rvalid or a pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdog <= '0;
        end else if (state == IDLE || sram_rvalid) begin
            wdog <= '0;
        end else if (own_en) begin
            wdog <= bus_err ? 16'd0 : wdog + 16'd1;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Remember the owner on entry to a burst for the next tie-break.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last <= 1'b0;
        end else if (state == IDLE && state_nxt == OWN1) begin
            last <= 1'b1;
        end else if (state == IDLE && state_nxt == OWN0) begin
            last <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Randomized bench for cache_bus_arbiter with a burst-level reference model.
module tb_cache_bus_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int T  = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_en, m1_en;
    logic [DW/8-1:0] m0_wen, m1_wen;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_rvalid, m1_rvalid;
    logic [DW-1:0] m_rdata;
    logic          sram_en;
    logic [DW/8-1:0] sram_wen;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata;
    logic          sram_rvalid;
    logic [1:0]    grant;
    logic          bus_err;

    cache_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(T)) dut (
        .clk(clk), .rst(rst),
        .m0_en(m0_en), .m0_wen(m0_wen), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rvalid(m0_rvalid),
        .m1_en(m1_en), .m1_wen(m1_wen), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rvalid(m1_rvalid),
        .m_rdata(m_rdata), .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_rvalid(sram_rvalid),
        .grant(grant), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int n_err = 0;
    int n_rv0 = 0;

    // Reference: who owns the bus (0 none, 1 icache, 2 dcache), stalls since
    // the last completed beat, and which master held the bus most recently.
    int owner   = 0;
    int stalls  = 0;
    bit last_m1 = 1'b0;
    bit stall_mode = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            if (bad <= 30) $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        logic            e_en;
        logic [DW/8-1:0] e_wen;
        logic [AW-1:0]   e_addr;
        logic [DW-1:0]   e_wdata;
        e_en = 1'b0; e_wen = '0; e_addr = '0; e_wdata = '0;
        if (owner == 1) begin
            e_en = m0_en; e_wen = m0_wen; e_addr = m0_addr; e_wdata = m0_wdata;
        end else if (owner == 2) begin
            e_en = m1_en; e_wen = m1_wen; e_addr = m1_addr; e_wdata = m1_wdata;
        end
        chk("grant", 64'(grant), owner == 1 ? 64'd1 : owner == 2 ? 64'd2 : 64'd0);
        chk("sram_en", 64'(sram_en), 64'(e_en));
        chk("sram_wen", 64'(sram_wen), 64'(e_wen));
        chk("sram_addr", 64'(sram_addr), 64'(e_addr));
        chk("sram_wdata", 64'(sram_wdata), 64'(e_wdata));
        chk("m0_rvalid", 64'(m0_rvalid), 64'(owner == 1 && sram_rvalid));
        chk("m1_rvalid", 64'(m1_rvalid), 64'(owner == 2 && sram_rvalid));
        chk("m_rdata", 64'(m_rdata), 64'(sram_rdata));
        // The T-th consecutive stalled owned cycle raises the error.
        chk("bus_err", 64'(bus_err), 64'(owner != 0 && e_en && !sram_rvalid && stalls == T - 1));
        if (owner != 0 && e_en && !sram_rvalid && stalls == T - 1) n_err++;
        if (owner == 1 && sram_rvalid) n_rv0++;
    endtask

    task automatic model_step();
        bit oen;
        if (owner == 0) begin
            stalls = 0;
`ifdef ARB_ROUND_ROBIN_EN
            if (m0_en && m1_en) owner = last_m1 ? 1 : 2;
            else if (m1_en)     owner = 2;
            else if (m0_en)     owner = 1;
`else
            if (m1_en)      owner = 2;
            else if (m0_en) owner = 1;
`endif
            if (owner != 0) last_m1 = (owner == 2);
        end else begin
            oen = (owner == 1) ? m0_en : m1_en;
            if (sram_rvalid) stalls = 0;
            else if (oen) stalls = (stalls == T - 1) ? 0 : stalls + 1;
            if (!oen) owner = 0;
        end
    endtask

    task automatic model_reset();
        owner = 0; stalls = 0; last_m1 = 1'b0;
    endtask

    // Check combinational outputs mid-cycle, advance one edge, return at negedge.
    task automatic cycle();
        #1 check_all();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic drive_random();
        if (m0_en) m0_en = ($urandom_range(0, 19) != 0);
        else       m0_en = ($urandom_range(0, 3) == 0);
        if (m1_en) m1_en = ($urandom_range(0, 19) != 0);
        else       m1_en = ($urandom_range(0, 3) == 0);
        m0_wen = (DW/8)'($urandom); m1_wen = (DW/8)'($urandom);
        m0_addr = AW'($urandom);    m1_addr = AW'($urandom);
        m0_wdata = DW'($urandom);   m1_wdata = DW'($urandom);
        sram_rdata = DW'($urandom);
        if ($urandom_range(0, 29) == 0) stall_mode = ~stall_mode;
        sram_rvalid = stall_mode ? 1'b0 : ($urandom_range(0, 2) == 0);
    endtask

    initial begin
        rst = 1'b0;
        m0_en = 1'b1; m1_en = 1'b1;
        m0_wen = '0; m1_wen = '0; m0_addr = '0; m1_addr = '0;
        m0_wdata = '0; m1_wdata = '0; sram_rdata = 32'hDEADBEEF; sram_rvalid = 1'b1;
        model_reset();

        // Reset holds the bus idle even with both requesting and rvalid high.
        @(negedge clk);
        #1 check_all();
        @(negedge clk);
        rst = 1'b1;
        m0_en = 1'b0; m1_en = 1'b0; sram_rvalid = 1'b0;

        // icache burst on its own: beats at 0x1000.., rvalid two cycles after issue.
        m0_en = 1'b1;
        for (int b = 0; b < 16; b++) begin
            m0_addr = 32'h1000 + 32'(b * 4);
            sram_rvalid = 1'b0; cycle();
            cycle();
            sram_rvalid = 1'b1; sram_rdata = 32'hA000_0000 + 32'(b); cycle();
        end
        chk("burst_beats", 64'(n_rv0), 64'd16);
        m0_en = 1'b0; sram_rvalid = 1'b0; cycle(); cycle();

        // Simultaneous request: dcache first, one bubble, then icache.
        m0_en = 1'b1; m1_en = 1'b1;
        for (int c = 0; c < 4; c++) cycle();
        m1_en = 1'b0; cycle(); cycle(); cycle();
        m0_en = 1'b0; cycle(); cycle();

        // Stalled owner: watchdog pulses every T cycles, rvalid restarts it.
        m1_en = 1'b1;
        for (int c = 0; c < 3 * T; c++) begin
            sram_rvalid = (c == T + 5);
            cycle();
        end
        chk("wdog_pulses", 64'(n_err >= 2), 64'd1);
        m1_en = 1'b0; sram_rvalid = 1'b0; cycle(); cycle();

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            drive_random();
            cycle();
        end

        // Asynchronous reset mid-burst drops the bus within the same cycle.
        m0_en = 1'b1; m1_en = 1'b0; sram_rvalid = 1'b0;
        for (int c = 0; c < 4; c++) cycle();
        #2 rst = 1'b0;
        #1;
        chk("rst_sram_en", 64'(sram_en), 64'd0);
        chk("rst_grant", 64'(grant), 64'd0);
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 5; c++) cycle();
        chk("regrant", 64'(grant), 64'd1);

        // Stray rvalid while idle is dropped and is not an error.
        m0_en = 1'b0; cycle(); cycle();
        sram_rvalid = 1'b1; sram_rdata = 32'hDEADBEEF;
        cycle(); cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
